// File: rtl/stitch_pipeline_pkg.sv
// Shared definitions for the stitched-pipeline flow controller: stage limits,
// the occupancy width helper and a stage-wide mask type.
package stitch_pipeline_pkg;

    localparam int STAGES_MAX = 16;

    typedef logic [STAGES_MAX-1:0] stage_mask_t;

    function automatic int occ_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int popcount(input stage_mask_t m);
        int c;
        c = 0;
        for (int i = 0; i < STAGES_MAX; i++) begin
            c += int'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/stitch_stage_valid.sv
// One pipeline bank's valid bit with its accept/load/next-state logic.
// The downstream advance comes in from the next bank (or from out_ready for the last).
module stitch_stage_valid
    import stitch_pipeline_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic src,
    input  logic adv,
    output logic v,
    output logic acc,
    output logic load
);

    // A bank can take a new item when empty or when its current item leaves this cycle.
    assign acc  = ~v | adv;
    assign load = src & acc & ~flush & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (load) begin
            v <= 1'b1;
        end else if (adv) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/stitch_pipeline_ctrl.sv
// Valid/ready flow controller for a stitched STAGES-deep pipeline: per-bank load
// enables with full throughput, bubble collapse and output backpressure.
module stitch_pipeline_ctrl
    import stitch_pipeline_pkg::*;
#(
    parameter int STAGES = 2,
    localparam int OCC_W = occ_width(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_load,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic              idle
);

    // Built last bank first so each bank's advance is the load of the bank after it.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int K = STAGES - 1 - i;
        logic src;
        logic adv;
        logic acc;
        logic load;

        if (K == 0) begin : g_src_in
            assign src = in_valid;
        end else begin : g_src_prev
            assign src = stage_valid[K-1];
        end

        if (i == 0) begin : g_adv_out
            assign adv = stage_valid[K] & out_ready;
        end else begin : g_adv_next
            assign adv = g_stage[i-1].load;
        end

        stitch_stage_valid u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .src   (src),
            .adv   (adv),
            .v     (stage_valid[K]),
            .acc   (acc),
            .load  (load)
        );

        assign stage_load[K] = load;
    end

    assign in_ready  = g_stage[STAGES-1].acc & ~flush & ~rst;
    assign out_valid = stage_valid[STAGES-1] & ~flush;
    assign occupancy = OCC_W'(popcount(stage_mask_t'(stage_valid)));
    assign idle      = (occupancy == '0) & ~in_valid;

endmodule

// File: tb/tb_stitch_pipeline_ctrl.sv
// Bench for stitch_pipeline_ctrl: three instances (2, 1 and 5 stages) driven in
// lockstep, compared against a slot-based item model plus a directed vector table.
module tb_stitch_pipeline_ctrl;

    logic clk;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic flush;

    logic       ir2, ov2, idle2;
    logic [1:0] sl2, sv2, occ2;
    logic       ir1, ov1, idle1;
    logic [0:0] sl1, sv1, occ1;
    logic       ir5, ov5, idle5;
    logic [4:0] sl5, sv5;
    logic [2:0] occ5;

    stitch_pipeline_ctrl #(.STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .out_valid(ov2),
        .out_ready(out_ready), .flush(flush), .stage_load(sl2), .stage_valid(sv2),
        .occupancy(occ2), .idle(idle2)
    );
    stitch_pipeline_ctrl #(.STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .out_valid(ov1),
        .out_ready(out_ready), .flush(flush), .stage_load(sl1), .stage_valid(sv1),
        .occupancy(occ1), .idle(idle1)
    );
    stitch_pipeline_ctrl #(.STAGES(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir5), .out_valid(ov5),
        .out_ready(out_ready), .flush(flush), .stage_load(sl5), .stage_valid(sv5),
        .occupancy(occ5), .idle(idle5)
    );

    logic [15:0] a_sl [3];
    logic [15:0] a_sv [3];
    logic [15:0] a_occ[3];
    logic        a_ir [3];
    logic        a_ov [3];
    logic        a_idl[3];

    assign a_sl[0] = 16'(sl2);  assign a_sv[0] = 16'(sv2);  assign a_occ[0] = 16'(occ2);
    assign a_sl[1] = 16'(sl1);  assign a_sv[1] = 16'(sv1);  assign a_occ[1] = 16'(occ1);
    assign a_sl[2] = 16'(sl5);  assign a_sv[2] = 16'(sv5);  assign a_occ[2] = 16'(occ5);
    assign a_ir[0] = ir2;  assign a_ov[0] = ov2;  assign a_idl[0] = idle2;
    assign a_ir[1] = ir1;  assign a_ov[1] = ov1;  assign a_idl[1] = idle1;
    assign a_ir[2] = ir5;  assign a_ov[2] = ov5;  assign a_idl[2] = idle5;

    int nst[3] = '{2, 1, 5};
    int slot[3][16];
    int tag_ctr;
    int checks;
    int failures;
    bit h_ov[3];
    bit h_ir[3];
    bit h_idl[3];
    bit [31:0] m_ov[3];
    bit [31:0] m_ir[3];
    bit [31:0] m_idl[3];

    typedef struct {
        bit       iv;
        bit       ordy;
        bit       fl;
        bit       ir;
        bit       ov;
        bit [1:0] sl;
        bit [1:0] sv;
        int       occ;
        bit       idle;
    } vec_t;

    vec_t tbl[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 16; k++)
                slot[d][k] = -1;
    endtask

    // Each item sits in a slot; it moves one slot on when the slot ahead is free
    // or being vacated this cycle, and leaves the last slot on out_ready.
    task automatic step(input bit iv, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        #1;
        for (int d = 0; d < 3; d++) begin
            int n;
            int cnt;
            bit [15:0] full;
            bit [15:0] ld;
            bit e_ov, e_ir, room, srcp, retire;
            n    = nst[d];
            full = '0;
            for (int k = 0; k < 16; k++) full[k] = (slot[d][k] >= 0);
            e_ov   = full[n-1] & ~fl;
            retire = e_ov & ordy;
            room   = ~full[n-1] | retire;
            ld     = '0;
            e_ir   = 1'b0;
            for (int k = n - 1; k >= 0; k--) begin
                if (k == 0) begin
                    srcp = iv;
                    e_ir = room & ~fl;
                end else begin
                    srcp = full[k-1];
                end
                ld[k] = srcp & room & ~fl;
                if (k > 0) room = ~full[k-1] | ld[k];
            end
            cnt = $countones(full);
            chk($sformatf("s%0d_in_ready", n),    32'(a_ir[d]),  32'(e_ir));
            chk($sformatf("s%0d_out_valid", n),   32'(a_ov[d]),  32'(e_ov));
            chk($sformatf("s%0d_stage_load", n),  32'(a_sl[d]),  32'(ld));
            chk($sformatf("s%0d_stage_valid", n), 32'(a_sv[d]),  32'(full));
            chk($sformatf("s%0d_occupancy", n),   32'(a_occ[d]), 32'(cnt));
            chk($sformatf("s%0d_idle", n),        32'(a_idl[d]), 32'((cnt == 0) && !iv));
            h_ov[d]  = a_ov[d];
            h_ir[d]  = a_ir[d];
            h_idl[d] = a_idl[d];
            if (fl) begin
                for (int k = 0; k < 16; k++) slot[d][k] = -1;
            end else begin
                for (int k = n - 1; k >= 0; k--) begin
                    if (ld[k]) begin
                        if (k == 0) slot[d][k] = tag_ctr;
                        else        slot[d][k] = slot[d][k-1];
                    end else if ((k == n - 1 && retire) || (k < n - 1 && ld[k+1])) begin
                        slot[d][k] = -1;
                    end
                end
            end
            tag_ctr++;
        end
    endtask

    task automatic burst(input int nitems, input int ncyc);
        for (int d = 0; d < 3; d++) begin
            m_ov[d] = '0; m_ir[d] = '0; m_idl[d] = '0;
        end
        for (int c = 0; c < ncyc; c++) begin
            step(c < nitems, 1'b1, 1'b0);
            for (int d = 0; d < 3; d++) begin
                m_ov[d][c]  = h_ov[d];
                m_ir[d][c]  = h_ir[d];
                m_idl[d][c] = h_idl[d];
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        tag_ctr   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        model_clear();

        //            iv ordy fl  ir ov  sl     sv    occ idle
        tbl[0]  = '{1, 1, 0,  1, 0, 2'b01, 2'b00, 0, 0};
        tbl[1]  = '{0, 1, 0,  1, 0, 2'b10, 2'b01, 1, 0};
        tbl[2]  = '{0, 1, 0,  1, 1, 2'b00, 2'b10, 1, 0};
        tbl[3]  = '{0, 1, 0,  1, 0, 2'b00, 2'b00, 0, 1};
        tbl[4]  = '{1, 0, 0,  1, 0, 2'b01, 2'b00, 0, 0};
        tbl[5]  = '{1, 0, 0,  1, 0, 2'b11, 2'b01, 1, 0};
        tbl[6]  = '{1, 0, 0,  0, 1, 2'b00, 2'b11, 2, 0};
        tbl[7]  = '{1, 1, 0,  1, 1, 2'b11, 2'b11, 2, 0};
        tbl[8]  = '{0, 1, 0,  1, 1, 2'b10, 2'b11, 2, 0};
        tbl[9]  = '{1, 0, 0,  1, 1, 2'b01, 2'b10, 1, 0};
        tbl[10] = '{1, 1, 1,  0, 0, 2'b00, 2'b11, 2, 0};
        tbl[11] = '{0, 0, 0,  1, 0, 2'b00, 2'b00, 0, 1};

        // Reset: masks while rst high, cleared state once released.
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_in_ready_s%0d", nst[d]),   32'(a_ir[d]), 32'd0);
            chk($sformatf("rst_stage_load_s%0d", nst[d]), 32'(a_sl[d]), 32'd0);
        end
        in_valid = 1'b0;
        #1;
        chk("rst_idle_s2", 32'(idle2), 32'd1);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_stage_valid_s%0d", nst[d]), 32'(a_sv[d]),  32'd0);
            chk($sformatf("rst_occupancy_s%0d", nst[d]),   32'(a_occ[d]), 32'd0);
            chk($sformatf("rst_out_valid_s%0d", nst[d]),   32'(a_ov[d]),  32'd0);
        end

        // Directed vectors against the 2-stage instance.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].iv, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("vec%0d_in_ready", i),    32'(ir2),   32'(tbl[i].ir));
            chk($sformatf("vec%0d_out_valid", i),   32'(ov2),   32'(tbl[i].ov));
            chk($sformatf("vec%0d_stage_load", i),  32'(sl2),   32'(tbl[i].sl));
            chk($sformatf("vec%0d_stage_valid", i), 32'(sv2),   32'(tbl[i].sv));
            chk($sformatf("vec%0d_occupancy", i),   32'(occ2),  32'(tbl[i].occ));
            chk($sformatf("vec%0d_idle", i),        32'(idle2), 32'(tbl[i].idle));
        end

        // Asynchronous reset in the middle of a cycle with the pipe loaded.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk("pre_rst_stage_valid_s2", 32'(sv2), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst_stage_valid_s%0d", nst[d]), 32'(a_sv[d]),  32'd0);
            chk($sformatf("midrst_occupancy_s%0d", nst[d]),   32'(a_occ[d]), 32'd0);
            chk($sformatf("midrst_out_valid_s%0d", nst[d]),   32'(a_ov[d]),  32'd0);
            chk($sformatf("midrst_in_ready_s%0d", nst[d]),    32'(a_ir[d]),  32'd0);
        end
        @(negedge clk);
        chk("midrst_hold_in_ready_s2", 32'(ir2), 32'd0);
        rst = 1'b0;
        model_clear();
        #1;
        chk("postrst_in_ready_s2", 32'(ir2), 32'd1);
        in_valid = 1'b0;

        // Single item latency and 8-item back-to-back stream for every depth.
        burst(1, 10);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("single_ov_cycles_s%0d", nst[d]), m_ov[d], 32'h1 << nst[d]);
            chk($sformatf("single_idle_after_s%0d", nst[d]), 32'(m_idl[d][nst[d]+1]), 32'd1);
        end
        burst(8, 16);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("stream_ov_cycles_s%0d", nst[d]), m_ov[d], 32'hFF << nst[d]);
            chk($sformatf("stream_in_ready_s%0d", nst[d]), m_ir[d] & 32'hFF, 32'hFF);
        end

        // Random traffic with occasional flushes.
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
